uart_rx_cmd_ctrl: RTL and testbench

Command sequencer between the UART receiver and the register file. It parses the receiver's byte stream into write frames (WR_CMD, address, data) and read frames (RD_CMD, address). It issues single-cycle register-file strobes and hands read data to the UART transmitter. It is the only master of the register-file port on the UART side.

---
 rtl/uart_rx_cmd_ctrl_if.sv | 29 ++
 rtl/uart_rx_cmd_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Byte/strobe bundle between the UART command sequencer and its receiver, register file and
// transmitter. The sequencer takes the master modport.
interface uart_rx_cmd_ctrl_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [WIDTH-1:0]      rx_p_data;
    logic                  rx_d_vld;
    logic                  rf_wr_en;
    logic                  rf_rd_en;
    logic [ADDR_WIDTH-1:0] rf_address;
    logic [WIDTH-1:0]      rf_wr_data;
    logic [WIDTH-1:0]      rf_rd_data;
    logic                  rf_rd_data_vld;
    logic [WIDTH-1:0]      tx_p_data;
    logic                  tx_d_vld;
    logic                  tx_busy;
    logic                  cmd_error;

    modport master (
        input  rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld, tx_busy,
        output rf_wr_en, rf_rd_en, rf_address, rf_wr_data, tx_p_data, tx_d_vld, cmd_error
    );

    modport slave (
        output rx_p_data, rx_d_vld, rf_rd_data, rf_rd_data_vld, tx_busy,
        input  rf_wr_en, rf_rd_en, rf_address, rf_wr_data, tx_p_data, tx_d_vld, cmd_error
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// Parses UART bytes into register-file write/read frames and returns read data to the transmitter.
// Define CMD_TIMEOUT_EN to build the waiting-state timeout counter.
module uart_rx_cmd_ctrl #(
    parameter int unsigned     WIDTH      = 8,
    parameter int unsigned     ADDR_WIDTH = 4,
    parameter logic [WIDTH-1:0] WR_CMD    = 8'hAA,
    parameter logic [WIDTH-1:0] RD_CMD    = 8'hBB,
    parameter logic [15:0]     TIMEOUT    = 16'd50000
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    uart_rx_cmd_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        StIdle, StWrAddr, StWrData, StRdAddr, StRdWait, StTxSend
    } state_e;

    state_e                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [WIDTH-1:0]      r_wdata, w_wdata_nxt;
    logic [WIDTH-1:0]      r_txd, w_txd_nxt;
    logic                  r_wr_en, w_wr_en_nxt;
    logic                  r_rd_en, w_rd_en_nxt;
    logic                  r_tx_vld, w_tx_vld_nxt;
    logic                  r_err, w_err_nxt;

`ifdef CMD_TIMEOUT_EN
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        w_waiting, w_event;
`else
    logic        w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_txd_nxt    = r_txd;
        w_wr_en_nxt  = 1'b0;
        w_rd_en_nxt  = 1'b0;
        w_tx_vld_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.rx_d_vld) begin
                    if (bus.rx_p_data == WR_CMD)      w_state_nxt = StWrAddr;
                    else if (bus.rx_p_data == RD_CMD) w_state_nxt = StRdAddr;
                    else                              w_err_nxt   = 1'b1;
                end
            end
            StWrAddr: begin
                if (bus.rx_d_vld) begin
                    w_addr_nxt  = bus.rx_p_data[ADDR_WIDTH-1:0];
                    w_state_nxt = StWrData;
                end
            end
            StWrData: begin
                if (bus.rx_d_vld) begin
                    w_wdata_nxt = bus.rx_p_data;
                    w_wr_en_nxt = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            StRdAddr: begin
                if (bus.rx_d_vld) begin
                    w_addr_nxt  = bus.rx_p_data[ADDR_WIDTH-1:0];
                    w_rd_en_nxt = 1'b1;
                    w_state_nxt = StRdWait;
                end
            end
            StRdWait: begin
                if (bus.rf_rd_data_vld) begin
                    w_txd_nxt   = bus.rf_rd_data;
                    w_state_nxt = StTxSend;
                end
                if (bus.rx_d_vld) w_err_nxt = 1'b1;
            end
            StTxSend: begin
                if (!bus.tx_busy) begin
                    w_tx_vld_nxt = 1'b1;
                    w_state_nxt  = StIdle;
                end
                if (bus.rx_d_vld) w_err_nxt = 1'b1;
            end
            default: w_state_nxt = StIdle;
        endcase

`ifdef CMD_TIMEOUT_EN
        w_waiting = (r_state == StWrAddr) || (r_state == StWrData) ||
                    (r_state == StRdAddr) || (r_state == StRdWait);
        w_event   = (r_state == StRdWait) ? bus.rf_rd_data_vld : bus.rx_d_vld;
        w_cnt_nxt = 16'd0;
        // A byte dropped in RD_WAIT is not an accepted byte, so it keeps counting.
        if (w_waiting && !w_event) begin
            if (r_cnt == TIMEOUT - 16'd1) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = StIdle;
            end else begin
                w_cnt_nxt = r_cnt + 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_txd    <= '0;
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_tx_vld <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_txd    <= w_txd_nxt;
            r_wr_en  <= w_wr_en_nxt;
            r_rd_en  <= w_rd_en_nxt;
            r_tx_vld <= w_tx_vld_nxt;
            r_err    <= w_err_nxt;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= 16'd0;
        else          r_cnt <= w_cnt_nxt;
    end
`endif

    assign bus.rf_wr_en   = r_wr_en;
    assign bus.rf_rd_en   = r_rd_en;
    assign bus.rf_address = r_addr;
    assign bus.rf_wr_data = r_wdata;
    assign bus.tx_p_data  = r_txd;
    assign bus.tx_d_vld   = r_tx_vld;
    assign bus.cmd_error  = r_err;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Self-checking bench for uart_rx_cmd_ctrl: directed frames plus randomized write/read/bad-opcode
// traffic checked against frame-level expectations and global strobe tallies.
module tb_uart_rx_cmd_ctrl;
    localparam logic [7:0] WR = 8'hAA;
    localparam logic [7:0] RD = 8'hBB;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;
    int   exp_wr = 0, exp_rd = 0, exp_tx = 0, exp_err = 0;

    uart_rx_cmd_ctrl_if #(.WIDTH(8), .ADDR_WIDTH(4)) bus ();

    uart_rx_cmd_ctrl #(
        .WIDTH(8), .ADDR_WIDTH(4), .WR_CMD(WR), .RD_CMD(RD), .TIMEOUT(16'd20)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // High-cycle tallies: a stretched or spurious strobe shows up as an excess count.
    always @(negedge clk) begin
        if (rst_n) begin
            n_wr  += int'(bus.rf_wr_en);
            n_rd  += int'(bus.rf_rd_en);
            n_tx  += int'(bus.tx_d_vld);
            n_err += int'(bus.cmd_error);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_p_data = b;
        bus.rx_d_vld  = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_d_vld  = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input int gap);
        send_byte(WR);
        check_eq("wr_cmd_err", bus.cmd_error, 1'b0);
        repeat (gap) tick();
        send_byte(addr);
        check_eq("wr_early", bus.rf_wr_en, 1'b0);
        repeat (gap) tick();
        send_byte(data);
        check_eq("wr_en", bus.rf_wr_en, 1'b1);
        check_eq("wr_addr", bus.rf_address, {4'h0, addr[3:0]});
        check_eq("wr_data", bus.rf_wr_data, data);
        check_eq("wr_err", bus.cmd_error, 1'b0);
        exp_wr++;
        tick();
        check_eq("wr_pulse1", bus.rf_wr_en, 1'b0);
    endtask

    task automatic do_bad(input logic [7:0] b);
        send_byte(b);
        check_eq("bad_op_err", bus.cmd_error, 1'b1);
        exp_err++;
    endtask

    // gap: idle cycles between RF_RD_EN and read data; busy: cycles TX_BUSY stays high afterwards.
    task automatic do_read(input logic [7:0] addr, input logic [7:0] data, input int gap,
                           input int busy, input bit ovr_wait, input bit ovr_tx);
        int lat;
        send_byte(RD);
        check_eq("rd_cmd_err", bus.cmd_error, 1'b0);
        send_byte(addr);
        check_eq("rd_en", bus.rf_rd_en, 1'b1);
        check_eq("rd_addr", bus.rf_address, {4'h0, addr[3:0]});
        exp_rd++;
        repeat (gap) tick();
        if (ovr_wait) begin
            send_byte(8'($urandom));
            check_eq("ovr_wait_err", bus.cmd_error, 1'b1);
            exp_err++;
        end
        @(negedge clk);
        bus.rf_rd_data     = data;
        bus.rf_rd_data_vld = 1'b1;
        bus.tx_busy        = (busy > 0);
        tick();
        bus.rf_rd_data_vld = 1'b0;
        bus.rf_rd_data     = ~data;
        check_eq("txd_early", bus.tx_p_data, data);
        lat = 0;
        for (int i = 1; i <= busy + 5; i++) begin
            @(negedge clk);
            if (i > busy) bus.tx_busy = 1'b0;
            if (ovr_tx && busy > 0 && i == 1) begin
                bus.rx_p_data = 8'($urandom);
                bus.rx_d_vld  = 1'b1;
            end
            tick();
            bus.rx_d_vld = 1'b0;
            if (ovr_tx && busy > 0 && i == 1) begin
                check_eq("ovr_tx_err", bus.cmd_error, 1'b1);
                exp_err++;
            end
            if (bus.tx_d_vld) begin
                lat = i;
                break;
            end
        end
        check_eq("tx_lat", lat, busy + 1);
        check_eq("tx_data", bus.tx_p_data, data);
        exp_tx++;
    endtask

    initial begin
        logic [7:0] b;
        bus.rx_p_data      = '0;
        bus.rx_d_vld       = 1'b0;
        bus.rf_rd_data     = '0;
        bus.rf_rd_data_vld = 1'b0;
        bus.tx_busy        = 1'b0;
        rst_n              = 1'b0;
        #1;
        check_eq("rst_outs", {bus.rf_wr_en, bus.rf_rd_en, bus.tx_d_vld, bus.cmd_error,
                              bus.rf_address, bus.rf_wr_data, bus.tx_p_data}, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_write(8'h03, 8'h5C, 0);
        do_read(8'h07, 8'hE1, 1, 0, 1'b0, 1'b0);
        do_bad(8'h12);
        check_eq("bad_op_idle_wr", bus.rf_wr_en, 1'b0);
        do_write(8'h01, 8'hFF, 0);
        do_read(8'h0A, 8'h3C, 2, 100, 1'b0, 1'b1);
        do_write(8'hF6, 8'h00, 2);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0: do_write(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
                1: do_read(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
                default: begin
                    do begin
                        b = 8'($urandom);
                    end while (b == WR || b == RD);
                    do_bad(b);
                end
            endcase
        end

        // Reset between address and data of a write.
        do_read(8'h05, 8'hE1, 0, 0, 1'b0, 1'b0);
        send_byte(WR);
        send_byte(8'h07);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", {bus.rf_wr_en, bus.rf_rd_en, bus.tx_d_vld, bus.cmd_error,
                                  bus.rf_address, bus.rf_wr_data, bus.tx_p_data}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h5C);
        check_eq("rst_late_err", bus.cmd_error, 1'b1);
        check_eq("rst_late_wr", bus.rf_wr_en, 1'b0);
        exp_err++;
        do_write(8'h09, 8'h77, 0);

`ifdef CMD_TIMEOUT_EN
        send_byte(WR);
        send_byte(8'h04);
        for (int i = 1; i <= 19; i++) begin
            tick();
            check_eq("to_quiet", bus.cmd_error, 1'b0);
        end
        tick();
        check_eq("to_err", bus.cmd_error, 1'b1);
        check_eq("to_no_wr", bus.rf_wr_en, 1'b0);
        exp_err++;
        send_byte(WR);
        send_byte(8'h04);
        repeat (18) tick();
        send_byte(8'h6D);
        check_eq("to_edge_wr", bus.rf_wr_en, 1'b1);
        check_eq("to_edge_data", bus.rf_wr_data, 8'h6D);
        check_eq("to_edge_err", bus.cmd_error, 1'b0);
        exp_wr++;
`endif

        repeat (3) tick();
        check_eq("cnt_wr", n_wr, exp_wr);
        check_eq("cnt_rd", n_rd, exp_rd);
        check_eq("cnt_tx", n_tx, exp_tx);
        check_eq("cnt_err", n_err, exp_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
